// File: rtl/spi_sine_responder.sv
// SPI mode-0 slave that returns one {sin_index, uart_id} word per chip-select frame.
// Words are queued by a local producer through a 2-entry buffer.
module spi_sine_responder #(
  parameter int                   WORD_BITS   = 16,
  parameter logic [WORD_BITS-1:0] IDLE_WORD   = 16'hFFF0,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_clk,
  input  logic                 cs,
  output logic                 miso,
  input  logic [WORD_BITS-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 word_done,
  output logic                 underrun,
  output logic                 abort,
  output logic [1:0]           fifo_level,
  output logic                 busy
);

  localparam int CNT_W   = $clog2(WORD_BITS + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SHIFT        = 2'd1,
    ST_WAIT_CS_HIGH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [FLUSH_W-1:0]     r_flush_cnt;
  logic                   r_armed;

  logic [WORD_BITS-1:0]   r_mem [2];
  logic                   r_rd_ptr;
  logic                   r_wr_ptr;
  logic [1:0]             r_level;
  logic                   r_load_ready;

  state_t                 r_state;
  logic [WORD_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_miso;
  logic                   r_word_done;
  logic                   r_underrun;
  logic                   r_abort;
  logic                   r_busy;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_push;
  logic                   w_pop;
  logic [1:0]             w_level_nxt;
  logic [WORD_BITS-1:0]   w_head;

  state_t                 w_state_nxt;
  logic [WORD_BITS-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]       w_bit_cnt_nxt;
  logic                   w_miso_nxt;
  logic                   w_word_done_nxt;
  logic                   w_underrun_nxt;
  logic                   w_abort_nxt;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  // A cs fall only counts once cs has been seen high after reset, so a
  // frame already in progress at reset release is ignored.
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs_s;

  assign w_push = load_valid & r_load_ready;
  assign w_head = r_mem[r_rd_ptr];

  // Input synchronizers, edge-detect copies and post-reset arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush_cnt <= {FLUSH_W{1'b0}};
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (r_flush_cnt != FLUSH_W'(SYNC_STAGES)) begin
        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      end
      if ((r_flush_cnt == FLUSH_W'(SYNC_STAGES)) && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Buffer occupancy after this cycle's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 2'd1;
      2'b01:   w_level_nxt = r_level - 2'd1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Two-entry holding buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0]     <= {WORD_BITS{1'b0}};
      r_mem[1]     <= {WORD_BITS{1'b0}};
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_level      <= 2'd0;
      r_load_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= load_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_level      <= w_level_nxt;
      r_load_ready <= (w_level_nxt != 2'd2);
    end
  end

  // Transaction sequencing; cs rise is checked first so it beats a coincident spi_clk rise.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_miso_nxt      = 1'b0;
    w_word_done_nxt = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_abort_nxt     = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          if (r_level != 2'd0) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
          end else begin
            w_underrun_nxt = 1'b1;
            w_shift_nxt    = IDLE_WORD;
          end
          w_bit_cnt_nxt = {CNT_W{1'b0}};
          w_state_nxt   = ST_SHIFT;
          w_miso_nxt    = w_shift_nxt[WORD_BITS-1];
        end else begin
          w_miso_nxt = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
          w_miso_nxt  = 1'b0;
        end else if (w_sclk_rise) begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (w_bit_cnt_nxt == CNT_W'(WORD_BITS)) begin
            w_word_done_nxt = 1'b1;
            w_state_nxt     = ST_WAIT_CS_HIGH;
            w_miso_nxt      = 1'b0;
          end else begin
            w_miso_nxt = r_miso;
          end
        end else if (w_sclk_fall) begin
          w_shift_nxt = {r_shift[WORD_BITS-2:0], 1'b0};
          w_miso_nxt  = r_shift[WORD_BITS-2];
        end else begin
          w_miso_nxt = r_miso;
        end
      end
      ST_WAIT_CS_HIGH: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_CS_HIGH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, shifter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= {WORD_BITS{1'b0}};
      r_bit_cnt   <= {CNT_W{1'b0}};
      r_miso      <= 1'b0;
      r_word_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_miso      <= w_miso_nxt;
      r_word_done <= w_word_done_nxt;
      r_underrun  <= w_underrun_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign miso       = r_miso;
  assign load_ready = r_load_ready;
  assign word_done  = r_word_done;
  assign underrun   = r_underrun;
  assign abort      = r_abort;
  assign fifo_level = r_level;
  assign busy       = r_busy;

endmodule

// File: tb/tb_spi_sine_responder.sv
// Directed bench for spi_sine_responder: acts as SPI master and word producer.
module tb_spi_sine_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk;
  logic        cs;
  logic        miso;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        word_done;
  logic        underrun;
  logic        abort;
  logic [1:0]  fifo_level;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_wd = 0;
  int n_ur = 0;
  int n_ab = 0;

  spi_sine_responder dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .cs         (cs),
    .miso       (miso),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .word_done  (word_done),
    .underrun   (underrun),
    .abort      (abort),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Each status pulse is high for exactly one negedge when it lasts one cycle.
  always @(negedge clk) begin
    if (word_done) n_wd <= n_wd + 1;
    if (underrun)  n_ur <= n_ur + 1;
    if (abort)     n_ab <= n_ab + 1;
  end

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    load_data  = d;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // One master frame; optionally offers push_data on the cycle the word is popped.
  task automatic xfer(input int nrise, input logic push_en, input logic [15:0] push_data,
                      output logic [15:0] rx, output logic busy_mid);
    rx = 16'h0000;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    load_data  = push_data;
    load_valid = push_en;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    busy_mid = busy;
    for (int i = 0; i < nrise; i++) begin
      rx = {rx[14:0], miso};
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b1; spi_clk = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    checks++; if ({word_done, underrun, abort} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {word_done, underrun, abort}); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single();
    logic [15:0] rx; logic bm; int wd0, ur0, ab0;
    wd0 = n_wd; ur0 = n_ur; ab0 = n_ab;
    push(16'hA5C3);
    @(negedge clk);
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL single_level_pre got %0d exp 1", fifo_level); end
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'hA5C3) begin errors++; $display("FAIL single_data got %h exp a5c3", rx); end
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bm); end
    checks++; if (n_wd - wd0 !== 1) begin errors++; $display("FAIL single_word_done got %0d exp 1", n_wd - wd0); end
    checks++; if ((n_ur - ur0) + (n_ab - ab0) !== 0) begin errors++; $display("FAIL single_no_ur_ab got %0d exp 0", (n_ur - ur0) + (n_ab - ab0)); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL single_level_post got %0d exp 0", fifo_level); end
    checks++; if (miso !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got miso %b busy %b exp 0 0", miso, busy); end
  endtask

  task automatic test_underrun();
    logic [15:0] rx; logic bm; int wd0, ur0;
    wd0 = n_wd; ur0 = n_ur;
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'hFFF0) begin errors++; $display("FAIL underrun_data got %h exp fff0", rx); end
    checks++; if (n_ur - ur0 !== 1) begin errors++; $display("FAIL underrun_pulse got %0d exp 1", n_ur - ur0); end
    checks++; if (n_wd - wd0 !== 1) begin errors++; $display("FAIL underrun_word_done got %0d exp 1", n_wd - wd0); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL underrun_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_full();
    logic [15:0] rx; logic bm; int ur0;
    push(16'h0011);
    push(16'h0022);
    @(negedge clk);
    checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL full_level got %0d exp 2", fifo_level); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_load_ready got %b exp 0", load_ready); end
    push(16'h0033);
    @(negedge clk);
    checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL full_reject_level got %0d exp 2", fifo_level); end
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'h0011) begin errors++; $display("FAIL full_first got %h exp 0011", rx); end
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL full_level1 got %0d exp 1", fifo_level); end
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'h0022) begin errors++; $display("FAIL full_second got %h exp 0022", rx); end
    ur0 = n_ur;
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'hFFF0 || n_ur - ur0 !== 1) begin errors++; $display("FAIL full_third got %h ur %0d exp fff0 ur 1", rx, n_ur - ur0); end
  endtask

  task automatic test_abort();
    logic [15:0] rx; logic bm; int wd0, ur0, ab0;
    wd0 = n_wd; ab0 = n_ab;
    push(16'h1234);
    xfer(7, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'h0009) begin errors++; $display("FAIL abort_partial got %h exp 0009", rx); end
    checks++; if (n_ab - ab0 !== 1) begin errors++; $display("FAIL abort_pulse got %0d exp 1", n_ab - ab0); end
    checks++; if (n_wd - wd0 !== 0) begin errors++; $display("FAIL abort_no_word_done got %0d exp 0", n_wd - wd0); end
    checks++; if (fifo_level !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state got level %0d busy %b exp 0 0", fifo_level, busy); end
    ur0 = n_ur;
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'hFFF0 || n_ur - ur0 !== 1) begin errors++; $display("FAIL abort_next got %h ur %0d exp fff0 ur 1", rx, n_ur - ur0); end
  endtask

  task automatic test_pop_push();
    logic [15:0] rx; logic bm;
    push(16'h1111);
    push(16'h2222);
    xfer(16, 1'b1, 16'h3333, rx, bm);
    checks++; if (rx !== 16'h1111) begin errors++; $display("FAIL poppush_full_data got %h exp 1111", rx); end
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL poppush_full_level got %0d exp 1", fifo_level); end
    xfer(16, 1'b1, 16'h4444, rx, bm);
    checks++; if (rx !== 16'h2222) begin errors++; $display("FAIL poppush_same_data got %h exp 2222", rx); end
    checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL poppush_same_level got %0d exp 1", fifo_level); end
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'h4444) begin errors++; $display("FAIL poppush_order got %h exp 4444", rx); end
    checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL poppush_empty got %0d exp 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rx; logic bm; int ur0, wd0;
    push(16'h5555);
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spi_clk = 1'b1; repeat (5) @(negedge clk);
      spi_clk = 1'b0; repeat (5) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checks++; if (miso !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async got miso %b busy %b exp 0 0", miso, busy); end
    @(negedge clk);
    checks++; if (fifo_level !== 2'd0 || load_ready !== 1'b1) begin errors++; $display("FAIL midrst_fifo got level %0d ready %b exp 0 1", fifo_level, load_ready); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ur0 = n_ur; wd0 = n_wd;
    for (int i = 0; i < 16; i++) begin
      spi_clk = 1'b1; repeat (5) @(negedge clk);
      spi_clk = 1'b0; repeat (5) @(negedge clk);
    end
    checks++; if (busy !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL midrst_no_xfer got busy %b miso %b exp 0 0", busy, miso); end
    checks++; if ((n_ur - ur0) + (n_wd - wd0) !== 0) begin errors++; $display("FAIL midrst_no_pulses got %0d exp 0", (n_ur - ur0) + (n_wd - wd0)); end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    push(16'h6666);
    wd0 = n_wd;
    xfer(16, 1'b0, 16'h0000, rx, bm);
    checks++; if (rx !== 16'h6666 || n_wd - wd0 !== 1) begin errors++; $display("FAIL midrst_resume got %h wd %0d exp 6666 wd 1", rx, n_wd - wd0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_full();
    test_abort();
    test_pop_push();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
